data_mem_responder: RTL

- Handshaked data-memory responder: the slave end of the CPU's load/store interface.
- Accepts one request at a time (address, load/store, byte/half/word mask, sign-extend flag) and services it against an internal word array after a fixed latency.
- Returns a response through a valid/ready handshake.
- Replaces the zero-latency data memory when the core moves to a multi-cycle/stallable memory path.

---
 rtl/data_mem_responder.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/data_mem_responder.sv
// ---------------------------------------------------------------------------
// data_mem_responder
//   Slave end of the CPU load/store interface. Accepts one request at a time,
//   services it against an internal word array after a fixed latency and
//   returns the result through a valid/ready handshake.
//
// Ports
//   clk, rstn                 clock, asynchronous active-low reset
//   req_valid / req_ready     request handshake
//   req_write                 1 = store, 0 = load
//   req_maskmode              0 byte, 1 half, 2 word, 3 reserved
//   req_sext                  sign-extend byte/half load results
//   req_addr, req_wdata       byte address, right-aligned store data
//   resp_valid / resp_ready   response handshake
//   resp_rdata                right-aligned, extended load data (0 otherwise)
//   resp_error                request was illegal, no memory effect
// ---------------------------------------------------------------------------
module data_mem_responder #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [1:0]            req_maskmode,
    input  logic                  req_sext,
    input  logic [31:0]           req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_rdata,
    output logic                  resp_error
);

    localparam int unsigned DEPTH    = 2 ** (ADDR_WIDTH - 2);
    localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                  r_state;
    state_t                  w_next;
    logic [3:0]              r_cnt;
    logic [3:0]              w_cnt_next;

    // Fields latched on the accepting edge
    logic                    r_write;
    logic [1:0]              r_mode;
    logic                    r_sext;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_err;

    logic [DATA_WIDTH-1:0]   r_rdata;
    logic                    r_resp_err;

    logic [DATA_WIDTH-1:0]   r_mem [0:DEPTH-1];

    logic                    w_accept;
    logic                    w_req_err;
    logic [ADDR_WIDTH-3:0]   w_req_idx;
    logic [DATA_WIDTH-1:0]   w_wr_word;

    logic                    w_enter_resp;
    logic                    w_ld_write;
    logic [1:0]              w_ld_mode;
    logic                    w_ld_sext;
    logic [ADDR_WIDTH-1:0]   w_ld_addr;
    logic                    w_ld_err;
    logic [DATA_WIDTH-1:0]   w_rd_word;
    logic [7:0]              w_rd_byte;
    logic [15:0]             w_rd_half;
    logic [DATA_WIDTH-1:0]   w_ld_data;

    assign req_ready  = (r_state == S_IDLE);
    assign resp_valid = (r_state == S_RESP);
    assign resp_rdata = r_rdata;
    assign resp_error = r_resp_err;

    assign w_accept  = req_valid & req_ready;
    assign w_req_idx = req_addr[ADDR_WIDTH-1:2];

    // Legality of the request currently presented on the inputs
    always_comb begin
        w_req_err = 1'b0;
        if (req_maskmode == 2'd3)                          w_req_err = 1'b1;
        if (req_maskmode == 2'd1 && req_addr[0])           w_req_err = 1'b1;
        if (req_maskmode == 2'd2 && req_addr[1:0] != 2'b00) w_req_err = 1'b1;
        if (|req_addr[31:ADDR_WIDTH])                      w_req_err = 1'b1;
    end

    // Store data merged into the current word so untouched lanes are kept
    always_comb begin
        w_wr_word = r_mem[w_req_idx];
        case (req_maskmode)
            2'd0: begin
                case (req_addr[1:0])
                    2'd0:    w_wr_word[7:0]   = req_wdata[7:0];
                    2'd1:    w_wr_word[15:8]  = req_wdata[7:0];
                    2'd2:    w_wr_word[23:16] = req_wdata[7:0];
                    default: w_wr_word[31:24] = req_wdata[7:0];
                endcase
            end
            2'd1: begin
                if (req_addr[1]) w_wr_word[31:16] = req_wdata[15:0];
                else             w_wr_word[15:0]  = req_wdata[15:0];
            end
            2'd2:    w_wr_word = req_wdata;
            default: ;
        endcase
    end

    // Next-state logic
    always_comb begin
        w_next     = r_state;
        w_cnt_next = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (LATENCY == 1) begin
                        w_next = S_RESP;
                    end else begin
                        w_next     = S_WAIT;
                        w_cnt_next = CNT_INIT;
                    end
                end
            end
            S_WAIT: begin
                w_cnt_next = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_enter_resp = (w_next == S_RESP) && (r_state != S_RESP);

    // With LATENCY == 1 the response is built on the accepting edge itself,
    // before the fields are latched, so the live inputs are used instead.
    always_comb begin
        if (r_state == S_IDLE) begin
            w_ld_write = req_write;
            w_ld_mode  = req_maskmode;
            w_ld_sext  = req_sext;
            w_ld_addr  = req_addr[ADDR_WIDTH-1:0];
            w_ld_err   = w_req_err;
        end else begin
            w_ld_write = r_write;
            w_ld_mode  = r_mode;
            w_ld_sext  = r_sext;
            w_ld_addr  = r_addr;
            w_ld_err   = r_err;
        end
    end

    // Lane extraction and extension of the load result
    always_comb begin
        w_rd_word = r_mem[w_ld_addr[ADDR_WIDTH-1:2]];
        case (w_ld_addr[1:0])
            2'd0:    w_rd_byte = w_rd_word[7:0];
            2'd1:    w_rd_byte = w_rd_word[15:8];
            2'd2:    w_rd_byte = w_rd_word[23:16];
            default: w_rd_byte = w_rd_word[31:24];
        endcase
        w_rd_half = w_ld_addr[1] ? w_rd_word[31:16] : w_rd_word[15:0];
        case (w_ld_mode)
            2'd0:    w_ld_data = {{(DATA_WIDTH-8){w_ld_sext & w_rd_byte[7]}}, w_rd_byte};
            2'd1:    w_ld_data = {{(DATA_WIDTH-16){w_ld_sext & w_rd_half[15]}}, w_rd_half};
            default: w_ld_data = w_rd_word;
        endcase
    end

    // Control and response registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_write    <= 1'b0;
            r_mode     <= '0;
            r_sext     <= 1'b0;
            r_addr     <= '0;
            r_err      <= 1'b0;
            r_rdata    <= '0;
            r_resp_err <= 1'b0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_next;
            if (w_accept) begin
                r_write <= req_write;
                r_mode  <= req_maskmode;
                r_sext  <= req_sext;
                r_addr  <= req_addr[ADDR_WIDTH-1:0];
                r_err   <= w_req_err;
            end
            if (w_enter_resp) begin
                r_rdata    <= (w_ld_err || w_ld_write) ? '0 : w_ld_data;
                r_resp_err <= w_ld_err;
            end else if (r_state == S_RESP && resp_ready) begin
                r_rdata    <= '0;
                r_resp_err <= 1'b0;
            end
        end
    end

    // Array is never cleared; a store commits on its accepting edge
    always_ff @(posedge clk) begin
        if (w_accept && req_write && !w_req_err) begin
            r_mem[w_req_idx] <= w_wr_word;
        end
    end

endmodule
